interrupt_controller: RTL and testbench

Processor-side interrupt controller: the receiving end of the peripherals' BUS_INTERRUPT_RAISE / BUS_INTERRUPT_ACK handshake. It collects up to eight level-held raise lines from memory-mapped peripherals such as the timer, masks them and selects one by fixed priority. It presents a single request plus vector to the CPU, and on the CPU's acknowledge returns a one-cycle ack to the selected peripheral. It sits on the shared 8-bit data/address bus as a memory-mapped slave at CtrlBaseAddr..+3.

---
 rtl/interrupt_controller.sv | 106 ++++++++++
 tb/tb_interrupt_controller.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// Fixed-priority interrupt controller: masks up to eight raise lines, requests the CPU,
// returns a one-cycle ack to the serviced source, and exposes a 4-byte register window.
module interrupt_controller #(
    parameter logic [7:0] CtrlBaseAddr = 8'hE0,
    parameter logic [7:0] InitialMask  = 8'hFF
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    input  logic [7:0] IRQ_RAISE,
    output logic [7:0] IRQ_ACK,
    output logic       CPU_INT_REQ,
    output logic [2:0] CPU_INT_VECTOR,
    input  logic       CPU_INT_ACK
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t     state;
    logic [2:0] vector;
    logic [7:0] mask;
    logic [7:0] dispatch_count;
    logic       rd_sel;
    logic [1:0] rd_off;

    logic [7:0] eligible;
    logic [2:0] lowest;
    logic [7:0] addr_off;
    logic       addr_hit;
    logic [7:0] rd_data;

    assign eligible = IRQ_RAISE & mask;

    // Scan downwards so the lowest set index is the last assignment and wins.
    always_comb begin
        lowest = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (eligible[i]) lowest = 3'(i);
        end
    end

    // Offset arithmetic keeps the decode correct for any base, aligned or not.
    assign addr_off = BUS_ADDR - CtrlBaseAddr;
    assign addr_hit = (addr_off < 8'd4);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state          <= IDLE;
            vector         <= 3'd0;
            mask           <= InitialMask;
            dispatch_count <= 8'd0;
            rd_sel         <= 1'b0;
            rd_off         <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (eligible != 8'd0) begin
                        vector <= lowest;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (CPU_INT_ACK) state <= ACK;
                end
                ACK: begin
                    dispatch_count <= dispatch_count + 8'd1;
                    state          <= HOLD;
                end
                default: state <= IDLE;
            endcase

            // Placed after the FSM so a clear of the count overrides the ACK increment.
            if (BUS_WE && addr_hit) begin
                if (addr_off[1:0] == 2'd1) mask <= BUS_DATA;
                if (addr_off[1:0] == 2'd3) dispatch_count <= 8'd0;
            end

            rd_sel <= addr_hit && !BUS_WE;
            rd_off <= addr_off[1:0];
        end
    end

    assign CPU_INT_REQ    = (state == REQ);
    assign CPU_INT_VECTOR = vector;
    assign IRQ_ACK        = (state == ACK) ? (8'd1 << vector) : 8'd0;

    always_comb begin
        rd_data = 8'd0;
        case (rd_off)
            2'd0: rd_data = IRQ_RAISE;
            2'd1: rd_data = mask;
            2'd2: rd_data = {state, 3'b000, vector};
            default: rd_data = dispatch_count;
        endcase
    end

    assign BUS_DATA = rd_sel ? rd_data : 8'hzz;

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: stimulus queues expected REQ/ACK/read events
// with due cycles; a negedge monitor matches every DUT output event against the queue.
module tb_interrupt_controller;

    localparam int EV_REQ = 0;
    localparam int EV_ACK = 1;
    localparam int EV_RD  = 2;

    typedef struct {
        int         kind;
        logic [7:0] val;
        int         due;
    } ev_t;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] BUS_ADDR = 8'h00;
    logic       BUS_WE = 1'b0;
    logic [7:0] IRQ_RAISE = 8'h00;
    logic       CPU_INT_ACK = 1'b0;
    logic [7:0] IRQ_ACK;
    logic       CPU_INT_REQ;
    logic [2:0] CPU_INT_VECTOR;
    wire  [7:0] bus_data;
    logic [7:0] bus_drv = 8'h00;
    logic       bus_oe = 1'b0;

    ev_t  exp_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_bad = 0;
    logic mon_en = 1'b0;
    logic req_q = 1'b0;

    assign bus_data = bus_oe ? bus_drv : 8'hzz;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    interrupt_controller #(.CtrlBaseAddr(8'hE0), .InitialMask(8'hFF)) dut (
        .CLK(CLK), .RESET(RESET), .BUS_DATA(bus_data), .BUS_ADDR(BUS_ADDR),
        .BUS_WE(BUS_WE), .IRQ_RAISE(IRQ_RAISE), .IRQ_ACK(IRQ_ACK),
        .CPU_INT_REQ(CPU_INT_REQ), .CPU_INT_VECTOR(CPU_INT_VECTOR),
        .CPU_INT_ACK(CPU_INT_ACK)
    );

    function automatic string kname(int k);
        case (k)
            EV_REQ:  return "req";
            EV_ACK:  return "ack";
            default: return "rd";
        endcase
    endfunction

    task automatic push(int kind, logic [7:0] val, int dly);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.due  = cyc + dly;
        exp_q.push_back(e);
    endtask

    task automatic got(int kind, logic [7:0] val);
        int idx = -1;
        n_chk++;
        foreach (exp_q[i]) if (idx < 0 && exp_q[i].kind == kind) idx = i;
        if (idx < 0) begin
            n_bad++;
            $display("FAIL unexpected_%s: got %h at cycle %0d, none expected", kname(kind), val, cyc);
        end else begin
            if (exp_q[idx].val !== val || exp_q[idx].due != cyc) begin
                n_bad++;
                $display("FAIL %s: got %h at cycle %0d, want %h at cycle %0d",
                         kname(kind), val, cyc, exp_q[idx].val, exp_q[idx].due);
            end
            exp_q.delete(idx);
        end
    endtask

    // Monitor: sample mid-cycle, well away from the active edge and the stimulus updates.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (CPU_INT_REQ && !req_q) got(EV_REQ, {5'b0, CPU_INT_VECTOR});
            if (IRQ_ACK != 8'h00) got(EV_ACK, IRQ_ACK);
            if (!bus_oe && (bus_data !== 8'hzz)) got(EV_RD, bus_data);
            req_q = CPU_INT_REQ;
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].due < cyc) begin
                    n_chk++;
                    n_bad++;
                    $display("FAIL missing_%s: want %h at cycle %0d, got nothing by cycle %0d",
                             kname(exp_q[i].kind), exp_q[i].val, exp_q[i].due, cyc);
                    exp_q.delete(i);
                end
            end
        end
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic rd(logic [7:0] addr, logic [7:0] exp);
        BUS_ADDR = addr;
        BUS_WE   = 1'b0;
        push(EV_RD, exp, 1);
        step();
        BUS_ADDR = 8'h00;
        step();
    endtask

    task automatic wr(logic [7:0] addr, logic [7:0] d);
        BUS_ADDR = addr;
        BUS_WE   = 1'b1;
        bus_drv  = d;
        bus_oe   = 1'b1;
        step();
        BUS_WE   = 1'b0;
        bus_oe   = 1'b0;
        BUS_ADDR = 8'h00;
    endtask

    // Returns in the ACK cycle: the ack was sampled at the most recent edge.
    task automatic cpu_ack(logic [7:0] onehot);
        CPU_INT_ACK = 1'b1;
        push(EV_ACK, onehot, 1);
        step();
        CPU_INT_ACK = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        chk("rst_req", 8'(CPU_INT_REQ), 8'h00);
        chk("rst_vector", 8'(CPU_INT_VECTOR), 8'h00);
        chk("rst_irq_ack", IRQ_ACK, 8'h00);
        chk("rst_bus_z", 8'(bus_data === 8'hzz), 8'h01);
        mon_en = 1'b1;
        RESET  = 1'b0;
        step();
        rd(8'hE1, 8'hFF);
        rd(8'hE2, 8'h00);
        rd(8'hE3, 8'h00);
        rd(8'hE0, 8'h00);

        // Stray CPU ack in IDLE must do nothing.
        CPU_INT_ACK = 1'b1;
        step();
        CPU_INT_ACK = 1'b0;
        step();

        // Single source, CPU acks three cycles into the request.
        IRQ_RAISE = 8'h01;
        push(EV_REQ, 8'd0, 1);
        repeat (3) step();
        cpu_ack(8'h01);
        IRQ_RAISE = 8'h00;
        repeat (3) step();
        chk("req_low_after_ack", 8'(CPU_INT_REQ), 8'h00);
        rd(8'hE3, 8'h01);

        // Priority: 1 before 3, then 3 again back-to-back.
        IRQ_RAISE = 8'h0A;
        push(EV_REQ, 8'd1, 1);
        repeat (2) step();
        cpu_ack(8'h02);
        IRQ_RAISE = 8'h08;
        push(EV_REQ, 8'd3, 3);
        repeat (3) step();
        cpu_ack(8'h08);
        IRQ_RAISE = 8'h00;
        repeat (3) step();

        // Mask out source 1: only 3 is serviced.
        wr(8'hE1, 8'hFD);
        IRQ_RAISE = 8'h0A;
        push(EV_REQ, 8'd3, 1);
        step();
        cpu_ack(8'h08);
        IRQ_RAISE = 8'h02;
        repeat (6) step();
        IRQ_RAISE = 8'h00;
        rd(8'hE1, 8'hFD);
        wr(8'hE1, 8'hFF);

        // No preemption: source 0 arrives while 5 is requesting.
        IRQ_RAISE = 8'h20;
        push(EV_REQ, 8'd5, 1);
        step();
        IRQ_RAISE = 8'h21;
        repeat (2) step();
        cpu_ack(8'h20);
        IRQ_RAISE = 8'h01;
        push(EV_REQ, 8'd0, 3);
        repeat (3) step();
        cpu_ack(8'h01);
        IRQ_RAISE = 8'h00;
        repeat (3) step();

        // Bus access, status read during REQ, mask write and raise drop during REQ.
        wr(8'hE1, 8'h55);
        rd(8'hE1, 8'h55);
        wr(8'hE1, 8'hFF);
        IRQ_RAISE = 8'h40;
        push(EV_REQ, 8'd6, 1);
        step();
        rd(8'hE2, 8'h46);
        IRQ_RAISE = 8'h00;
        wr(8'hE1, 8'h00);
        cpu_ack(8'h40);
        repeat (3) step();
        IRQ_RAISE = 8'h93;
        rd(8'hE0, 8'h93);
        IRQ_RAISE = 8'h00;
        rd(8'hE2, 8'h06);
        wr(8'hE1, 8'hFF);
        rd(8'hE3, 8'h07);
        wr(8'hE3, 8'hA5);
        rd(8'hE3, 8'h00);

        // 256 back-to-back dispatches, one every 4 cycles, wrap the count to 0.
        IRQ_RAISE   = 8'h01;
        CPU_INT_ACK = 1'b1;
        for (int i = 0; i < 256; i++) begin
            push(EV_REQ, 8'd0, 1 + 4 * i);
            push(EV_ACK, 8'h01, 2 + 4 * i);
        end
        repeat (1024) step();
        IRQ_RAISE   = 8'h00;
        CPU_INT_ACK = 1'b0;
        step();
        rd(8'hE3, 8'h00);

        // Count clear coinciding with the ACK cycle wins over the increment.
        IRQ_RAISE = 8'h04;
        push(EV_REQ, 8'd2, 1);
        step();
        cpu_ack(8'h04);
        IRQ_RAISE = 8'h00;
        wr(8'hE3, 8'h00);
        rd(8'hE3, 8'h00);

        // Reset while requesting: no ack, everything back to reset values.
        wr(8'hE1, 8'h0F);
        IRQ_RAISE = 8'h08;
        push(EV_REQ, 8'd3, 1);
        step();
        RESET       = 1'b1;
        CPU_INT_ACK = 1'b1;
        step();
        chk("midreq_rst_req", 8'(CPU_INT_REQ), 8'h00);
        chk("midreq_rst_vector", 8'(CPU_INT_VECTOR), 8'h00);
        chk("midreq_rst_irq_ack", IRQ_ACK, 8'h00);
        chk("midreq_rst_bus_z", 8'(bus_data === 8'hzz), 8'h01);
        RESET       = 1'b0;
        CPU_INT_ACK = 1'b0;
        IRQ_RAISE   = 8'h00;
        step();
        rd(8'hE1, 8'hFF);
        rd(8'hE2, 8'h00);

        repeat (4) step();
        chk("queue_empty", 8'(exp_q.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
